mips_program_loader: RTL
========================

Name: mips_program_loader

Overview:
- Upstream boot stage for the single-cycle MIPS core.
- Accepts a byte stream over a valid/ready handshake and assembles 32-bit instruction words, most significant byte first.
- Writes each word into instruction memory at consecutive word addresses, then checks a trailing checksum.
- Holds the core in reset until a load completes with a matching checksum.

Parameters:
Data_Width, 32, instruction word width; the byte packing logic is fixed at 4 bytes per word.
Addr_Width, 10, instruction memory word-address width.
Max_Words, 1024, largest accepted program length in words; must be <= 2**Addr_Width.

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a load
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream payload
in_ready  output  1  loader can accept a byte
im_we  output  1  instruction memory write enable
im_addr  output  Addr_Width  instruction memory word address
im_wdata  output  Data_Width  instruction memory write data
core_rst  output  1  reset to the MIPS core; 1 = core held in reset
busy  output  1  load in progress
done  output  1  load succeeded, core running
error  output  1  load failed
words_loaded  output  Addr_Width+1  count of words written in the current load

Behaviour:
- Byte transfer occurs on any cycle where in_valid && in_ready.
- in_ready = 1 only in HDR, DATA and CHK. It does not depend on in_valid.
- Reset, on any cycle and including mid-load:
  - state = IDLE; core_rst = 1.
  - in_ready, im_we, busy, done and error = 0.
  - im_addr, im_wdata, words_loaded, checksum and byte index = 0.
- States: IDLE, HDR, DATA, CHK, RUN, ERR.
- IDLE:
  - start -> HDR; clear words_loaded, checksum and byte index.
- HDR:
  - Collect 4 bytes, MSB first, into word count N.
  - On the 4th byte: if N == 0 or N > Max_Words -> ERR; otherwise -> DATA.
- DATA:
  - Collect 4 bytes per word, MSB first.
  - The cycle after the 4th byte is accepted: im_we = 1 for exactly one cycle, im_addr = words_loaded[Addr_Width-1:0], im_wdata = assembled word.
  - On that same cycle: words_loaded increments and checksum += word (mod 2**32).
  - Byte acceptance continues unstalled during the write cycle, so back-to-back bytes are sustained at 1 byte/cycle.
  - After word N is written -> CHK.
- CHK:
  - Collect 4 bytes, MSB first, as the expected checksum.
  - The cycle after the 4th byte: match -> RUN; mismatch -> ERR.
- RUN: core_rst = 0, done = 1, busy = 0.
- ERR: core_rst = 1, error = 1, busy = 0.
- busy = 1 in HDR, DATA and CHK.
- start handling:
  - start is ignored while busy.
  - start in RUN or ERR -> HDR. On that transition edge: core_rst returns to 1, done and error clear, and counters clear.
- im_addr and im_wdata hold their last values while im_we = 0.
- Outputs are registered. core_rst drops in the first cycle of RUN.
- N == Max_Words is legal; the final word is written at address Max_Words-1.
- The checksum adder wraps silently at 2**32.
- in_valid deasserted mid-word: the partial word and byte index are held indefinitely; there is no timeout.
- Bytes presented while in IDLE, RUN or ERR are not accepted (in_ready = 0).

Test Plan:
- Reset values: rst=1 for 2 cycles -> core_rst=1; in_ready=0; im_we=0; busy=0; done=0; error=0; words_loaded=0.
- Nominal two-word load:
  - Stimulus: start, then bytes 00 00 00 02 | 20 08 00 05 | 01 09 50 20 | 21 11 50 25, back-to-back.
  - Expected writes: addr0=0x20080005, addr1=0x01095020, each im_we a single-cycle pulse one cycle after its 4th byte.
  - Expected end state: RUN, core_rst=0, done=1, words_loaded=2.
- Checksum mismatch: same stream with last byte 0x26 -> ERR, error=1, core_rst=1, done=0; both words still written.
- Header bounds:
  - N=0 -> ERR immediately after the 4th header byte, with no im_we.
  - N=Max_Words+1 -> ERR.
  - N=Max_Words with wrapping checksum (all words 0xFFFFFFFF) -> RUN, last write at addr Max_Words-1.
- Gapped stream: in_valid toggles 1/0 every cycle through a 1-word load -> same im_wdata as back-to-back; start pulsed mid-load is ignored.
- Reset and reload:
  - rst after the 2nd data byte of word 1 -> IDLE; no write issued.
  - Fresh start with a full 1-word load -> RUN.
  - Subsequent start from RUN -> core_rst=1 next cycle, done=0, words_loaded=0.

Source files
------------

// File: rtl/mips_program_loader.sv
// mips_program_loader: boot-time byte-stream loader for the single-cycle MIPS core.
// Receives a length header, the program words (MSB first) and a trailing checksum,
// writes the words into instruction memory and releases the core only on a good load.
module mips_program_loader #(
  parameter int Data_Width = 32,
  parameter int Addr_Width = 10,
  parameter int Max_Words  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [Addr_Width-1:0] im_addr,
  output logic [Data_Width-1:0] im_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [Addr_Width:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CHK,
    RUN,
    ERR
  } state_t;

  state_t state, state_next;

  logic [1:0]            byte_idx;
  logic [Data_Width-9:0] shift_reg;
  logic [Data_Width-1:0] assembled;
  logic [Data_Width-1:0] checksum;
  logic [Addr_Width:0]   word_count;
  logic [Addr_Width:0]   words_inc;
  logic                  accept;
  logic                  last_byte;
  logic                  hdr_bad;
  logic                  clear_counters;
  logic                  ready_next;
  logic                  busy_next;
  logic                  done_next;
  logic                  error_next;
  logic                  core_rst_next;

  assign accept         = in_valid && in_ready;
  assign last_byte      = (byte_idx == 2'd3);
  assign assembled      = {shift_reg, in_data};
  assign words_inc      = words_loaded + (Addr_Width+1)'(1);
  assign hdr_bad        = (assembled == '0) || (assembled > Data_Width'(Max_Words));
  assign clear_counters = start && ((state == IDLE) || (state == RUN) || (state == ERR));

  // Next-state selection and the status outputs that follow the next state.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (start) state_next = HDR;
      HDR:      if (accept && last_byte) state_next = hdr_bad ? ERR : DATA;
      DATA:     if (accept && last_byte && (words_inc == word_count)) state_next = CHK;
      CHK:      if (accept && last_byte) state_next = (assembled == checksum) ? RUN : ERR;
      RUN, ERR: if (start) state_next = HDR;
      default:  state_next = IDLE;
    endcase
    ready_next    = (state_next == HDR) || (state_next == DATA) || (state_next == CHK);
    busy_next     = ready_next;
    done_next     = (state_next == RUN);
    error_next    = (state_next == ERR);
    core_rst_next = (state_next != RUN);
  end

  // State register with registered status outputs so they change together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= ready_next;
      busy     <= busy_next;
      done     <= done_next;
      error    <= error_next;
      core_rst <= core_rst_next;
    end
  end

  // Byte assembly, memory write pulse, word counter and running checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx     <= 2'd0;
      shift_reg    <= '0;
      word_count   <= '0;
      words_loaded <= '0;
      checksum     <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
    end else begin
      im_we <= 1'b0;
      if (clear_counters) begin
        byte_idx     <= 2'd0;
        words_loaded <= '0;
        checksum     <= '0;
      end else if (accept) begin
        byte_idx  <= byte_idx + 2'd1;
        shift_reg <= assembled[Data_Width-9:0];
        if ((state == HDR) && last_byte) begin
          word_count <= assembled[Addr_Width:0];
        end
        if ((state == DATA) && last_byte) begin
          im_we        <= 1'b1;
          im_addr      <= words_loaded[Addr_Width-1:0];
          im_wdata     <= assembled;
          words_loaded <= words_inc;
          checksum     <= checksum + assembled;
        end
      end
    end
  end

endmodule
